branch_resolve_unit: RTL and testbench

- Execute-side partner of the fetch-stage branch lookup table (LUT).
- Records every prediction the fetch stage makes in an in-order in-flight queue.
- When the instruction resolves in EX, compares the actual outcome against the recorded prediction.
- On a mismatch, issues the 33-bit LUT update word, a pipeline flush and a redirect PC; it also keeps branch and mispredict statistics.

---
 rtl/branch_resolve_unit_if.sv | 35 +++
 rtl/branch_resolve_unit.sv | 98 +++++++++
 tb/tb_branch_resolve_unit.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute/LUT-update signal bundle for the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             if_valid;
  logic [15:0]      if_pc;
  logic             if_pred_taken;
  logic [15:0]      if_pred_target;
  logic             ex_valid;
  logic             ex_is_branch;
  logic             ex_taken;
  logic [15:0]      ex_offset;
  logic             q_full;
  logic             lut_write_en;
  logic [32:0]      lut_write_data;
  logic             flush;
  logic [15:0]      redirect_pc;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;
  logic             underflow;

  modport slave (
    input  if_valid, if_pc, if_pred_taken, if_pred_target,
    input  ex_valid, ex_is_branch, ex_taken, ex_offset,
    output q_full, lut_write_en, lut_write_data, flush, redirect_pc,
    output branch_count, mispredict_count, underflow
  );

  modport master (
    output if_valid, if_pc, if_pred_taken, if_pred_target,
    output ex_valid, ex_is_branch, ex_taken, ex_offset,
    input  q_full, lut_write_en, lut_write_data, flush, redirect_pc,
    input  branch_count, mispredict_count, underflow
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Tracks fetch-time branch predictions in order and, at EX resolve, emits
// LUT correction, flush and redirect on a mispredict; keeps statistics.
module branch_resolve_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  clr_n,
  branch_resolve_unit_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [15:0] pc;
    logic        pred_taken;
    logic [15:0] pred_target;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic             empty, full, pop, push, mispredict, actual_taken;
  entry_t           head;
  logic [15:0]      seq_pc, actual_next, pred_next;
  logic             flush_q, lut_we_q, underflow_q;
  logic [32:0]      lut_data_q;
  logic [15:0]      redirect_q;
  logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

  // Queue status and resolve compare against the head entry
  always_comb begin
    empty        = (wr_ptr == rd_ptr);
    full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    head         = mem[rd_ptr[AW-1:0]];
    pop          = bus.ex_valid && !empty && !flush_q;
    push         = bus.if_valid && (!full || pop);
    rd_ptr_nxt   = pop ? PW'(rd_ptr + PW'(1)) : rd_ptr;
    seq_pc       = 16'(head.pc + 16'd1);
    actual_taken = bus.ex_is_branch && bus.ex_taken;
    actual_next  = actual_taken ? 16'(head.pc + bus.ex_offset) : seq_pc;
    pred_next    = head.pred_taken ? head.pred_target : seq_pc;
    mispredict   = pop && (pred_next != actual_next);
  end

  // Entry storage; a push in the flushing cycle is squashed
  always_ff @(posedge clk) begin
    if (push && !mispredict) begin
      mem[wr_ptr[AW-1:0]] <= '{pc: bus.if_pc, pred_taken: bus.if_pred_taken,
                               pred_target: bus.if_pred_target};
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      flush_q          <= 1'b0;
      lut_we_q         <= 1'b0;
      lut_data_q       <= '0;
      redirect_q       <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      underflow_q      <= 1'b0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (mispredict) begin
        wr_ptr <= rd_ptr_nxt;
      end else if (push) begin
        wr_ptr <= PW'(wr_ptr + PW'(1));
      end
      flush_q    <= mispredict;
      lut_we_q   <= mispredict;
      lut_data_q <= mispredict ? {head.pc, bus.ex_offset, actual_taken} : 33'd0;
      if (mispredict) begin
        redirect_q <= actual_next;
      end
      if (pop && bus.ex_is_branch && (branch_cnt_q != '1)) begin
        branch_cnt_q <= CNT_W'(branch_cnt_q + CNT_W'(1));
      end
      if (mispredict && (mispredict_cnt_q != '1)) begin
        mispredict_cnt_q <= CNT_W'(mispredict_cnt_q + CNT_W'(1));
      end
      // Resolve with nothing in flight is a sticky protocol error
      if (bus.ex_valid && empty && !flush_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.q_full           = full;
  assign bus.lut_write_en     = lut_we_q;
  assign bus.lut_write_data   = lut_data_q;
  assign bus.flush            = flush_q;
  assign bus.redirect_pc      = redirect_q;
  assign bus.branch_count     = branch_cnt_q;
  assign bus.mispredict_count = mispredict_cnt_q;
  assign bus.underflow        = underflow_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic,
// checked every cycle against a queue-based behavioural model.
module tb_branch_resolve_unit;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int CMAX = (1 << CNT_W) - 1;

  typedef struct {
    logic [15:0] pc;
    logic        pt;
    logic [15:0] tg;
  } ent_t;

  logic clk, clr_n;
  branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();
  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr_n(clr_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t        q[$];
  logic        m_we, m_flush, m_uf;
  logic [32:0] m_data;
  logic [15:0] m_redir;
  int          m_bc, m_mc;
  int          n_vec, n_cmp, n_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we = 0; m_flush = 0; m_uf = 0; m_data = '0; m_redir = '0; m_bc = 0; m_mc = 0;
  endtask

  task automatic model_step(input logic iv, input logic [15:0] pc, input logic pt,
                            input logic [15:0] tg, input logic ev, input logic br,
                            input logic tk, input logic [15:0] off);
    int          sz;
    logic        do_pop, mis;
    ent_t        h;
    logic [15:0] act_next, pred_next;
    sz = q.size();
    do_pop = ev && (sz > 0) && !m_flush;
    if (ev && (sz == 0) && !m_flush) m_uf = 1;
    mis = 0;
    h = '{pc: 16'h0, pt: 1'b0, tg: 16'h0};
    act_next = 16'h0;
    if (do_pop) begin
      h = q.pop_front();
      act_next  = (br && tk) ? 16'(h.pc + off) : 16'(h.pc + 16'd1);
      pred_next = h.pt ? h.tg : 16'(h.pc + 16'd1);
      mis = (act_next != pred_next);
      if (br && m_bc != CMAX) m_bc++;
      if (mis && m_mc != CMAX) m_mc++;
    end
    if (mis) q.delete();
    else if (iv && (sz < DEPTH || do_pop)) q.push_back('{pc: pc, pt: pt, tg: tg});
    m_we    = mis;
    m_flush = mis;
    m_data  = mis ? {h.pc, off, br & tk} : 33'd0;
    if (mis) m_redir = act_next;
  endtask

  task automatic check_all();
    chk("q_full",           64'(bus.q_full),           64'(q.size() == DEPTH));
    chk("lut_write_en",     64'(bus.lut_write_en),     64'(m_we));
    chk("lut_write_data",   64'(bus.lut_write_data),   64'(m_data));
    chk("flush",            64'(bus.flush),            64'(m_flush));
    chk("redirect_pc",      64'(bus.redirect_pc),      64'(m_redir));
    chk("branch_count",     64'(bus.branch_count),     64'(m_bc));
    chk("mispredict_count", 64'(bus.mispredict_count), 64'(m_mc));
    chk("underflow",        64'(bus.underflow),        64'(m_uf));
  endtask

  task automatic drive(input logic iv, input logic [15:0] pc, input logic pt,
                       input logic [15:0] tg, input logic ev, input logic br,
                       input logic tk, input logic [15:0] off);
    bus.if_valid = iv; bus.if_pc = pc; bus.if_pred_taken = pt; bus.if_pred_target = tg;
    bus.ex_valid = ev; bus.ex_is_branch = br; bus.ex_taken = tk; bus.ex_offset = off;
  endtask

  // One clock with the given inputs, then model update and full output check
  task automatic cycle(input logic iv, input logic [15:0] pc, input logic pt,
                       input logic [15:0] tg, input logic ev, input logic br,
                       input logic tk, input logic [15:0] off);
    drive(iv, pc, pt, tg, ev, br, tk, off);
    @(posedge clk);
    model_step(iv, pc, pt, tg, ev, br, tk, off);
    #1;
    n_vec++;
    check_all();
  endtask

  task automatic push(input logic [15:0] pc, input logic pt, input logic [15:0] tg);
    cycle(1'b1, pc, pt, tg, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic resolve(input logic br, input logic tk, input logic [15:0] off);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, br, tk, off);
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_err = 0;
    drive(0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0);
    clr_n = 1'b1;
    #1 clr_n = 1'b0;
    model_reset();
    #2;
    check_all();
    @(posedge clk); #1 clr_n = 1'b1;

    // Not-taken prediction, taken branch: mispredict with LUT update
    push(16'h0010, 1'b0, 16'h0011);
    resolve(1'b1, 1'b1, 16'h0008);
    chk("lit_we",    64'(bus.lut_write_en),     64'd1);
    chk("lit_data",  64'(bus.lut_write_data),   64'h0_0020_0011);
    chk("lit_model", 64'(m_data),               64'h0_0020_0011);
    chk("lit_redir", 64'(bus.redirect_pc),      64'h0018);
    chk("lit_mc1",   64'(bus.mispredict_count), 64'd1);

    // Correct taken prediction: no write, no flush
    push(16'h0020, 1'b1, 16'h0025);
    resolve(1'b1, 1'b1, 16'h0005);
    chk("lit_we0",   64'(bus.lut_write_en),     64'd0);
    chk("lit_bc2",   64'(bus.branch_count),     64'd2);
    chk("lit_mc1b",  64'(bus.mispredict_count), 64'd1);

    // Fill, drop on full, push+pop while full, in-order drain across wrap
    for (int i = 0; i < 5; i++) push(16'(16'h0100 + i), 1'b1, 16'(16'h0100 + 2 * i + 2));
    chk("lit_full",  64'(bus.q_full), 64'd1);
    cycle(1'b1, 16'h0105, 1'b1, 16'h010C, 1'b1, 1'b1, 1'b1, 16'h0002);
    chk("lit_full2", 64'(bus.q_full), 64'd1);
    resolve(1'b1, 1'b1, 16'h0003);
    resolve(1'b1, 1'b1, 16'h0004);
    resolve(1'b1, 1'b1, 16'h0005);
    resolve(1'b1, 1'b1, 16'h0007);
    chk("lit_bc7",   64'(bus.branch_count),     64'd7);
    chk("lit_mc1c",  64'(bus.mispredict_count), 64'd1);

    // Mispredict empties queue; ex_valid during flush ignored, then underflow
    for (int i = 0; i < 3; i++) push(16'(16'h0200 + i), 1'b0, 16'(16'h0201 + i));
    resolve(1'b1, 1'b1, 16'h0004);
    chk("lit_flush", 64'(bus.flush), 64'd1);
    resolve(1'b0, 1'b0, 16'h0000);
    chk("lit_uf0",   64'(bus.underflow), 64'd0);
    resolve(1'b0, 1'b0, 16'h0000);
    chk("lit_uf1",   64'(bus.underflow), 64'd1);
    cycle(0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0);
    chk("lit_uf1b",  64'(bus.underflow), 64'd1);
    chk("lit_mc2",   64'(bus.mispredict_count), 64'd2);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] rpc;
      rpc = 16'($urandom);
      cycle(($urandom % 3) != 0, rpc, 1'($urandom), 16'(rpc + 16'($urandom_range(0, 3))),
            ($urandom % 2) == 0, 1'($urandom), 1'($urandom), 16'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-operation with a mispredict about to resolve
    @(posedge clk); #1 clr_n = 1'b0;
    model_reset();
    #1 clr_n = 1'b1;
    push(16'h0300, 1'b0, 16'h0301);
    push(16'h0301, 1'b0, 16'h0302);
    drive(0, 16'h0, 0, 16'h0, 1, 1, 1, 16'h0010);
    #2 clr_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_we",    64'(bus.lut_write_en), 64'd0);
    chk("rst_cnt",   64'(bus.branch_count), 64'd0);
    drive(0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0);
    #2 clr_n = 1'b1;
    cycle(0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0);
    cycle(0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0);
    chk("rst_nowr",  64'(bus.lut_write_en), 64'd0);

    // Drive counters into saturation
    for (int i = 0; i < CMAX + 5; i++) begin
      push(16'(16'h0400 + i), 1'b0, 16'(16'h0401 + i));
      resolve(1'b1, 1'b1, 16'h0020);
    end
    chk("sat_mc",    64'(bus.mispredict_count), 64'hFF);
    chk("sat_bc",    64'(bus.branch_count),     64'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
